// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// WIDTH-bit operands LSB-first, with a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sh_a, sh_b, res, res_next;
  logic             c, s, c_next;
  logic [CW-1:0]    cnt;
  logic             last, accept;

  // Full-adder cell on the current LSBs.
  always_comb begin
    s        = sh_a[0] ^ sh_b[0] ^ c;
    c_next   = (sh_a[0] & sh_b[0]) | (sh_a[0] & c) | (sh_b[0] & c);
    res_next = (res >> 1) | ({{(WIDTH-1){1'b0}}, s} << (WIDTH-1));
    last     = (cnt == CW'(WIDTH-1));
    accept   = start && (state != RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a     <= '0;
      sh_b     <= '0;
      res      <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      // Subtract is a + ~b + 1, so the forced carry-in replaces cin.
      sh_a <= a;
      sh_b <= sub ? ~b : b;
      c    <= sub ? 1'b1 : cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      res  <= res_next;
      c    <= c_next;
      cnt  <= cnt + CW'(1);
      if (last) begin
        // On the MSB step the carry flop still holds the carry into the MSB.
        sum      <= res_next;
        cout     <= c_next;
        overflow <= c ^ c_next;
      end
    end
  end

endmodule
